// File: rtl/pwm_capture.sv
// pwm_capture
//   Measures an asynchronous PWM input. Each complete cycle, bounded by two
//   successive rising edges, is reported as a period and a high time, both in
//   clk counts. If no rising edge arrives for MAX clocks, the timeout flag is
//   raised. The synchronized input level is exported so that a stalled line
//   can be classified as stuck-high or stuck-low.
//
// Ports
//   clk        system clock; all logic runs on its rising edge
//   reset      asynchronous, active-high; clears all state and outputs
//   enable     capture enable; when low the FSM is forced to IDLE
//   pwm_in     asynchronous PWM input
//   period     clk edges between the last two rising edges
//   high_time  clk cycles pwm_in was high within that period
//   valid      one-cycle pulse when period/high_time update
//   timeout    no rising edge for MAX clocks; sticky until the next rise
//   level      synchronized pwm_in (s2)
//
// States
//   IDLE    | waiting for the first rise after reset, enable or timeout
//   MEASURE | counting; each rise closes one cycle and starts the next
module pwm_capture #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             timeout,
  output logic             level
);

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t state, state_next;

  logic s1, s2, s3;
  logic rise;

  logic [WIDTH-1:0] cnt, hcnt;

  logic start;
  logic capture;
  logic advance;
  logic expire;

  // The synchronizer keeps running while disabled, so a line that is
  // already high when enable returns is not mistaken for a rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise  = s2 & ~s3;
  assign level = s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (rise) state_next = MEASURE;
        MEASURE: if (!rise && cnt == MAX) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // A rise takes priority over the terminal count, so a period of exactly
  // MAX is still reported rather than flagged as a timeout.
  always_comb begin
    start   = 1'b0;
    capture = 1'b0;
    advance = 1'b0;
    expire  = 1'b0;
    if (enable) begin
      case (state)
        IDLE:    start = rise;
        MEASURE: begin
          if (rise)             capture = 1'b1;
          else if (cnt == MAX)  expire  = 1'b1;
          else                  advance = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Counters start at 1 on a rise because the rise cycle itself is the
  // first cycle of the new period and, with s2 high, of its high time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      hcnt      <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      valid <= capture;
      if (!enable) begin
        cnt     <= '0;
        hcnt    <= '0;
        timeout <= 1'b0;
      end else if (start || capture) begin
        cnt  <= ONE;
        hcnt <= ONE;
        if (start) timeout <= 1'b0;
        if (capture) begin
          period    <= cnt;
          high_time <= hcnt;
        end
      end else if (expire) begin
        timeout <= 1'b1;
      end else if (advance) begin
        cnt <= cnt + ONE;
        if (s2) hcnt <= hcnt + ONE;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Testbench for pwm_capture (WIDTH = 8). The reference model records every
// input sample by edge index and derives reports from rise timestamps:
// period is the distance between rise-processing edges, and high time is
// the number of high samples in the closed cycle.
module tb_pwm_capture;

  localparam int W    = 8;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         pwm_in;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         valid;
  logic         timeout;
  logic         level;

  always #5 clk = ~clk;

  pwm_capture #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .pwm_in    (pwm_in),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .timeout   (timeout),
    .level     (level)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int           k     = 0;
  int           rbase = 0;
  int           last  = 0;
  bit           armed = 0;
  logic         hist [0:19999];
  logic [W-1:0] m_period  = '0;
  logic [W-1:0] m_high    = '0;
  logic         m_valid   = 1'b0;
  logic         m_timeout = 1'b0;
  logic         saw_timeout;

  // Samples taken before the latest reset release are seen as low.
  function automatic logic samp(int idx);
    if (idx < 0 || idx < rbase) return 1'b0;
    return hist[idx];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d edge=%0d", tag, obs, exp, k);
    end
  endtask

  // A rise seen at input sample n is processed at edge n+2.
  task automatic model_edge();
    int s;
    m_valid = 1'b0;
    if (!enable) begin
      armed     = 0;
      m_timeout = 1'b0;
    end else if (samp(k - 2) && !samp(k - 3)) begin
      if (armed) begin
        s = 0;
        for (int j = last - 2; j <= k - 3; j++) s += int'(samp(j));
        m_period = W'(k - last);
        m_high   = W'(s);
        m_valid  = 1'b1;
      end
      armed     = 1;
      last      = k;
      m_timeout = 1'b0;
    end else if (armed && (k - last) == MAXV) begin
      m_timeout = 1'b1;
      armed     = 0;
    end
  endtask

  task automatic cyc(input logic b);
    pwm_in  = b;
    hist[k] = b;
    @(posedge clk);
    model_edge();
    k++;
    @(negedge clk);
    chk("period",    32'(period),    32'(m_period));
    chk("high_time", 32'(high_time), 32'(m_high));
    chk("valid",     32'(valid),     32'(m_valid));
    chk("timeout",   32'(timeout),   32'(m_timeout));
    chk("level",     32'(level),     32'(samp(k - 2)));
    if (timeout) saw_timeout = 1'b1;
  endtask

  task automatic pwm(int t, int h, int n);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < t; j++)
        cyc(j < h);
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_period"},    32'(period),    32'd0);
    chk({tag, "_high_time"}, 32'(high_time), 32'd0);
    chk({tag, "_valid"},     32'(valid),     32'd0);
    chk({tag, "_timeout"},   32'(timeout),   32'd0);
    chk({tag, "_level"},     32'(level),     32'd0);
  endtask

  // Asserted right after a falling edge; outputs must clear without a clock.
  task automatic do_reset(int hold);
    reset = 1'b1;
    #1;
    check_zero("rst_async");
    m_period  = '0;
    m_high    = '0;
    m_valid   = 1'b0;
    m_timeout = 1'b0;
    armed     = 0;
    for (int i = 0; i < hold; i++) begin
      pwm_in = ~pwm_in;
      @(negedge clk);
      check_zero("rst_hold");
    end
    reset = 1'b0;
    rbase = k;
  endtask

  initial begin
    int t, h, n;
    reset       = 1'b1;
    enable      = 1'b1;
    pwm_in      = 1'b0;
    saw_timeout = 1'b0;
    @(negedge clk);
    do_reset(4);

    // Steady PWM, then a duty change, then the minimum period.
    pwm(10, 3, 6);
    pwm(10, 7, 3);
    pwm(2, 1, 6);

    // Randomized cycles.
    for (int r = 0; r < 25; r++) begin
      t = $urandom_range(40, 2);
      h = $urandom_range(t - 1, 1);
      n = $urandom_range(3, 1);
      pwm(t, h, n);
    end

    // Stuck high after a rise.
    pwm(10, 5, 2);
    saw_timeout = 1'b0;
    for (int i = 0; i < 300; i++) cyc(1'b1);
    chk("stuck_high_timeout_seen", 32'(saw_timeout), 32'd1);
    chk("stuck_high_level",        32'(level),       32'd1);
    pwm(10, 5, 3);

    // Stuck low.
    saw_timeout = 1'b0;
    for (int i = 0; i < 300; i++) cyc(1'b0);
    chk("stuck_low_timeout_seen", 32'(saw_timeout), 32'd1);
    chk("stuck_low_level",        32'(level),       32'd0);
    pwm(10, 5, 3);

    // Enable dropped mid-period for 20 cycles.
    pwm(10, 3, 3);
    for (int j = 0; j < 5; j++) cyc(j < 3);
    enable = 1'b0;
    for (int j = 5; j < 10; j++) cyc(j < 3);
    pwm(10, 3, 1);
    for (int j = 0; j < 5; j++) cyc(j < 3);
    enable = 1'b1;
    for (int j = 5; j < 10; j++) cyc(j < 3);
    pwm(10, 3, 4);

    // Reset mid-period between two reports.
    pwm(10, 3, 3);
    for (int j = 0; j < 4; j++) cyc(j < 3);
    do_reset(3);
    pwm(10, 3, 4);
    pwm(7, 2, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform: synchronizes the asynchronous input, detects rising edges, and reports the period and high time of each complete cycle in system clock counts. It is the receive end of the team's PWM generator path and is used for loop-back checking and for measuring external PWM sources. A timeout flags a stalled input (0 % or 100 % duty, or a disconnected line).

## Interface
- WIDTH, 16, width of counters and measurement outputs; MAX = 2^WIDTH − 1

- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high; clears all state and outputs
- enable  input  1  capture enable; low forces IDLE
- pwm_in  input  1  asynchronous PWM input
- period  output  WIDTH  clocks between the last two rising edges
- high_time  output  WIDTH  clocks pwm_in was high within that period
- valid  output  1  one-cycle pulse when period/high_time update
- timeout  output  1  no rising edge for MAX clocks; sticky until next rise
- level  output  1  synchronized pwm_in (s2), meaningful with timeout

## Operation
- Synchronizer: s1 <= pwm_in, s2 <= s1, s3 <= s2; rise = s2 & ~s3. No falling-edge logic needed.
- States: IDLE (waiting for first rise), MEASURE.
- IDLE: on rise -> MEASURE, cnt <= 1, hcnt <= 1, timeout <= 0, no valid.
- MEASURE, rise: period <= cnt, high_time <= hcnt, valid <= 1, cnt <= 1, hcnt <= 1.
- MEASURE, no rise: cnt <= cnt + 1; hcnt <= hcnt + 1 if s2 = 1 else hold.
- MEASURE, cnt = MAX and no rise: timeout <= 1, -> IDLE, no valid; period/high_time keep last values.
- cnt and hcnt never wrap: timeout fires first; hcnt ≤ cnt always.
- enable = 0: state -> IDLE, cnt/hcnt <= 0, timeout <= 0, valid <= 0; period/high_time hold. Synchronizer keeps running, so a line already high at re-enable is not a rise.
- Rise on the same cycle enable returns high: enable takes effect first, i.e. treated as IDLE rise.
- Minimum measurable: period 2, high_time 1 (one-cycle high, one-cycle low at clk rate). Narrower pulses are lost in synchronization; not detected.

## Timing
- Reset values: period 0, high_time 0, valid 0, timeout 0, level 0, state IDLE, s1..s3 0, counters 0.
- Input latency: clk edge that first samples pwm_in high into s1 = edge 0; rise is true between edges 1 and 2; valid/period/high_time update at edge 2 and valid drops at edge 3.
- First report requires two rises after reset, enable, or timeout.
- period counts clk rising edges between successive rises exactly (period-T input -> period = T); high_time counts cycles with s2 = 1 starting with the rise cycle.
- timeout asserts the edge after cnt reaches MAX, i.e. MAX cycles after the last rise; clears at the edge that processes the next rise.
- Reset mid-measurement: all state cleared immediately (asynchronous); partial period discarded.

## Test plan
- Reset: hold pwm_in toggling, assert reset -> period = 0, high_time = 0, valid = 0, timeout = 0; after release no valid until second rise.
- WIDTH = 8, steady PWM period 10 high 3 -> first rise no valid; every later rise valid pulse of exactly 1 cycle with period = 10, high_time = 3, spacing 10 cycles, 3-edge latency from input edge.
- Duty change mid-stream: period 10, high 3 then high 7 -> reports 10/3, then 10/7 for the first full new cycle; min case period 2 high 1 -> 2/1.
- WIDTH = 8, pwm_in held high 300 cycles after a rise -> timeout = 1 exactly 255 cycles after that rise, level = 1, no valid; then resume period 10 high 5 -> first rise clears timeout with no valid, second rise valid 10/5. Repeat held low -> level = 0.
- enable deasserted mid-period for 20 cycles, then reasserted -> no valid while low, outputs hold last 10/3, first valid only after two rises post-enable.
- reset asserted mid-period between two valid reports -> outputs zero immediately, state IDLE, subsequent reports correct after two rises.
